// File: rtl/p_mul_gen.sv
// Packed shift-add multiplier: integer (signed/unsigned/mixed) and carry-less
// products per power-of-two lane, one multiplier bit per lane per cycle.
module p_mul_gen #(
   parameter int XLEN = 32,
   parameter int PWW  = $clog2(XLEN)
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            valid,
   output logic            ready,
   output logic            busy,
   input  logic            mul_l,
   input  logic            mul_h,
   input  logic            clmul,
   input  logic [1:0]      sgn,
   input  logic [PWW-1:0]  pw,
   input  logic [XLEN-1:0] crs1,
   input  logic [XLEN-1:0] crs2,
   output logic [XLEN-1:0] result
);

   // valid/ready: valid is held with stable operands until ready pulses for one
   // cycle with result; dropping valid earlier aborts and clears the datapath.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   logic [PWW:0]      count_q, count_d;
   logic [2*XLEN-1:0] psum_q, psum_d;
   state_e            state;
   logic              pw_ok;
   logic [PWW:0]      w_sel;
   logic [1:0]        sgn_eff;
   logic [2*XLEN-1:0] step_w [PWW];
   logic [XLEN-1:0]   hi_w   [PWW];
   logic [XLEN-1:0]   lo_w   [PWW];
   logic [2*XLEN-1:0] step_sel;
   logic [XLEN-1:0]   hi_sel;
   logic [XLEN-1:0]   lo_sel;

   // Carry-less ignores sign; the illegal {unsigned x signed} falls back to unsigned.
   assign sgn_eff = (clmul || sgn == 2'b01) ? 2'b00 : sgn;
   assign pw_ok   = (pw != '0) && ((pw & (pw - PWW'(1))) == '0);

   for (genvar k = 0; k < PWW; k++) begin : g_width
      localparam int W  = XLEN >> k;
      localparam int W2 = 2 * W;
      localparam int NL = XLEN / W;

      for (genvar j = 0; j < NL; j++) begin : g_lane
         logic [W-1:0] a;
         logic [W-1:0] b;
         logic [W-1:0] acc;
         logic [W-1:0] low;
         logic [W:0]   addend;
         logic [W:0]   acc_x;
         logic [W:0]   sum;
         logic         bit_i;
         logic         last;

         assign a     = crs1[j*W +: W];
         assign b     = crs2[j*W +: W];
         assign acc   = psum_q[W2*j + W +: W];
         assign low   = psum_q[W2*j +: W];
         assign bit_i = |(b & (W'(1) << count_q));
         assign last  = (count_q == (PWW+1)'(W - 1));

         always_comb begin
            addend = bit_i ? {sgn_eff[1] & a[W-1], a} : '0;
            acc_x  = {sgn_eff[1] & acc[W-1], acc};
            if (clmul) begin
               sum = {1'b0, acc ^ addend[W-1:0]};
            end else if (last && sgn_eff[0]) begin
               // Signed multiplier: the top bit carries negative weight.
               sum = acc_x - addend;
            end else begin
               sum = acc_x + addend;
            end
         end

         assign step_w[k][W2*j +: W2] = W2'({sum, low} >> 1);
         assign hi_w[k][j*W +: W]     = acc;
         assign lo_w[k][j*W +: W]     = low;
      end
   end

   always_comb begin
      w_sel    = (PWW+1)'(1);
      step_sel = '0;
      hi_sel   = '0;
      lo_sel   = '0;
      if (pw_ok) begin
         for (int k = 0; k < PWW; k++) begin
            if (pw[k]) begin
               w_sel    = (PWW+1)'(XLEN >> k);
               step_sel = step_w[k];
               hi_sel   = hi_w[k];
               lo_sel   = lo_w[k];
            end
         end
      end
   end

   // ">=" lets an illegal mid-operation width change still terminate.
   always_comb begin
      if (count_q == '0) begin
         state = ST_IDLE;
      end else if (count_q >= w_sel) begin
         state = ST_DONE;
      end else begin
         state = ST_RUN;
      end
   end

   always_comb begin
      count_d = count_q;
      psum_d  = psum_q;
      if (!valid) begin
         count_d = '0;
         psum_d  = '0;
      end else begin
         case (state)
            ST_IDLE, ST_RUN: begin
               count_d = count_q + (PWW+1)'(1);
               if (pw_ok) begin
                  psum_d = step_sel;
               end
            end
            ST_DONE: begin
               count_d = '0;
               psum_d  = '0;
            end
            default: begin
               count_d = '0;
               psum_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count_q <= '0;
         psum_q  <= '0;
      end else begin
         count_q <= count_d;
         psum_q  <= psum_d;
      end
   end

   assign ready = valid && (state == ST_DONE);
   assign busy  = (count_q != '0);

   always_comb begin
      result = '0;
      if (ready) begin
         if (mul_h) begin
            result = hi_sel;
         end else if (mul_l) begin
            result = lo_sel;
         end
      end
   end

endmodule
